// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART TX byte port among N_REQ requesters.
// Optional macro UART_ARB_ID_HEADER_EN: each grant first sends the winner's index as a header byte.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 7,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef UART_ARB_ID_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, XFER = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd2} state_t;
`endif

  state_t state, state_n;
  logic [IDX_W-1:0] g_idx, ptr, pick, cand;
  logic [7:0] burst_cnt, idle_cnt;
  logic found, xfer, hs, vld_g, last_g, done_burst, done_idle;
  logic [N_REQ-1:0] valid_m;
  logic [N_REQ-1:0][DATA_W-1:0] data_m;
  logic [DATA_W-1:0] data_g;

  // Per-requester passthrough: only the granted lane contributes to the shared bus.
  for (genvar k = 0; k < N_REQ; k++) begin : g_lane
    assign req_ready[k] = grant[k] & xfer & tx_ready;
    assign valid_m[k]   = grant[k] & req_valid[k];
    assign data_m[k]    = grant[k] ? req_data[k*DATA_W +: DATA_W] : '0;
  end

  always_comb begin
    data_g = '0;
    for (int k = 0; k < N_REQ; k++) data_g = data_g | data_m[k];
  end

  assign xfer       = (state == XFER);
  assign vld_g      = |valid_m;
  assign last_g     = |(grant & req_last);
  assign hs         = tx_valid & tx_ready;
  assign done_burst = (burst_cnt == 8'(MAX_BURST - 1));
  assign done_idle  = !vld_g && (idle_cnt == 8'(TIMEOUT - 1));
  assign busy       = (state != IDLE);

  // Rotating priority: first asserted request after the previous owner.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!found && req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
`ifdef UART_ARB_ID_HEADER_EN
      IDLE: if (|req_valid) state_n = HDR;
      HDR:  if (tx_ready) state_n = XFER;
`else
      IDLE: if (|req_valid) state_n = XFER;
`endif
      XFER: if ((hs && (last_g || done_burst)) || done_idle) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    case (state)
`ifdef UART_ARB_ID_HEADER_EN
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = DATA_W'(g_idx);
      end
`endif
      XFER: begin
        tx_valid = vld_g;
        tx_data  = data_g;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= '0;
      g_idx     <= '0;
      ptr       <= IDX_W'(N_REQ - 1);
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          g_idx     <= pick;
          burst_cnt <= '0;
          idle_cnt  <= '0;
        end
        XFER: begin
          if (hs) burst_cnt <= burst_cnt + 8'd1;
          idle_cnt <= vld_g ? 8'd0 : idle_cnt + 8'd1;
          if (state_n == IDLE) begin
            grant <= '0;
            ptr   <= g_idx;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed timing steps plus queued random messages against a segment-level model.
module tb_uart_tx_arbiter;
  localparam int NR = 4, DW = 7, MB = 16, TO = 32;
`ifdef UART_ARB_ID_HEADER_EN
  localparam int HL = 1;
`else
  localparam int HL = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0] req_valid, req_last, req_ready, grant;
  logic [NR*DW-1:0] req_data;
  logic tx_valid, tx_ready, busy;
  logic [DW-1:0] tx_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(NR), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant(grant), .busy(busy)
  );

  typedef struct {int idx; logic [DW-1:0] data; bit hdr; bit first;} exp_t;
  exp_t expq[$];
  logic [7:0] mem [NR][128];   // bit 7 = last-of-message flag
  int head[NR], tail[NR];
  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    for (int k = 0; k < NR; k++) begin head[k] = 0; tail[k] = 0; end
    expq.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add_msg(input int k, input int len);
    for (int i = 0; i < len; i++) begin
      mem[k][tail[k]] = {1'(i == len - 1), 7'($urandom_range(0, 127))};
      tail[k]++;
    end
  endtask

  // Segment model: rotate from the last owner; a segment ends at a last byte or after MB bytes.
  task automatic build_exp();
    int pos[NR];
    int p, k, n;
    bit lst;
    exp_t e;
    p = NR - 1;
    for (int j = 0; j < NR; j++) pos[j] = head[j];
    while (1) begin
      k = -1;
      for (int i = 1; i <= NR; i++)
        if (k < 0 && pos[(p + i) % NR] < tail[(p + i) % NR]) k = (p + i) % NR;
      if (k < 0) break;
      if (HL != 0) begin
        e.idx = k; e.data = DW'(k); e.hdr = 1'b1; e.first = 1'b1;
        expq.push_back(e);
      end
      n = 0; lst = 1'b0;
      while (!lst && n < MB) begin
        e.idx = k; e.data = mem[k][pos[k]][DW-1:0]; e.hdr = 1'b0;
        e.first = (n == 0) && (HL == 0);
        lst = mem[k][pos[k]][7];
        pos[k]++; n++;
        expq.push_back(e);
      end
      p = k;
    end
  endtask

  task automatic run_stream(input bit all_ready);
    int cyc, last_hs;
    bit hs;
    exp_t e;
    cyc = 0; last_hs = -1;
    while (expq.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        req_valid[k] = head[k] < tail[k];
        req_data[k*DW +: DW] = req_valid[k] ? mem[k][head[k]][DW-1:0] : '0;
        req_last[k] = req_valid[k] ? mem[k][head[k]][7] : 1'b0;
      end
      tx_ready = all_ready ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      hs = 1'b0;
      if (tx_valid) begin
        e = expq[0];
        check("grant", 32'(grant), 32'(1 << e.idx));
        check("tx_data", 32'(tx_data), 32'(e.data));
        check("req_ready", 32'(req_ready), (e.hdr || !tx_ready) ? 32'd0 : 32'(1 << e.idx));
        if (tx_ready) begin
          hs = 1'b1;
          if (all_ready && last_hs >= 0) check("gap", 32'(cyc - last_hs), e.first ? 32'd2 : 32'd1);
          last_hs = cyc;
        end
      end
      @(posedge clk);
      if (hs) begin
        e = expq.pop_front();
        if (!e.hdr) head[e.idx]++;
      end
      cyc++;
    end
    check("stream_left", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    do_reset();
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Arbitration latency, then reset while requester 2 owns the port
    @(negedge clk);
    req_valid = 4'b0100; req_data[2*DW +: DW] = 7'h55;
    #1;
    check("idle_grant", 32'(grant), 32'd0);
    @(posedge clk); #1;
    check("lat_grant", 32'(grant), 32'b0100);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_tx_valid", 32'(tx_valid), 32'd1);
    check("lat_tx_data", 32'(tx_data), (HL != 0) ? 32'h2 : 32'h55);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b1001; req_data = '0;
    @(posedge clk); #1;
    check("rr_after_rst", 32'(grant), 32'b0001);

    // Idle timeout on requester 0 with requester 3 waiting
    @(negedge clk);
    req_valid = 4'b1000; tx_ready = 1'b1;
    repeat (HL) @(posedge clk);
    for (int i = 1; i <= TO; i++) begin
      @(posedge clk); #1;
      if (i == TO - 1) check("to_hold", 32'(grant), 32'b0001);
      if (i == TO) begin
        check("to_release", 32'(grant), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
      end
    end
    @(posedge clk); #1;
    check("to_next", 32'(grant), 32'b1000);

    // Every requester sends one 2-byte message at full rate
    do_reset();
    for (int k = 0; k < NR; k++) add_msg(k, 2);
    build_exp();
    run_stream(1'b1);

    // Random messages with stalls; requester 1 long enough to hit the burst limit
    do_reset();
    add_msg(1, 20);
    add_msg(2, 5);
    for (int k = 0; k < NR; k++)
      for (int m = 0; m < 2; m++) add_msg(k, int'($urandom_range(1, 20)));
    build_exp();
    run_stream(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
